// File: rtl/mc_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mc_ctrl_pkg
// Description : Opcodes, FSM state encoding and the control word type for the
//               multicycle control unit.
// Revision    : 1.0
// ============================================================================
package mc_ctrl_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_ADDI  = 6'h08;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] ALUB_REG     = 2'b00;
    localparam logic [1:0] ALUB_FOUR    = 2'b01;
    localparam logic [1:0] ALUB_IMM     = 2'b10;
    localparam logic [1:0] ALUB_IMM_SH2 = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef enum logic [3:0] {
        ST_FETCH    = 4'd0,
        ST_DECODE   = 4'd1,
        ST_MEM_ADDR = 4'd2,
        ST_MEM_RD   = 4'd3,
        ST_MEM_WB   = 4'd4,
        ST_MEM_WR   = 4'd5,
        ST_R_EXEC   = 4'd6,
        ST_R_WB     = 4'd7,
        ST_I_EXEC   = 4'd8,
        ST_I_WB     = 4'd9,
        ST_BRANCH   = 4'd10,
        ST_JUMP     = 4'd11,
        ST_TRAP     = 4'd12
    } state_t;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_source;
    } ctrl_t;

endpackage : mc_ctrl_pkg
`default_nettype wire

// File: rtl/mc_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : mc_ctrl_if
// Description : Control-unit <-> datapath bundle: IR opcode and memory ready in,
//               datapath enables, mux selects and status out.
// Revision    : 1.0
// ============================================================================
interface mc_ctrl_if #(
    parameter int COUNT_W = 32
);
    logic [5:0]         opcode;
    logic               mem_ready;
    logic               pc_write;
    logic               pc_write_cond;
    logic               i_or_d;
    logic               mem_read;
    logic               mem_write;
    logic               ir_write;
    logic               mem_to_reg;
    logic               reg_dst;
    logic               reg_write;
    logic               alu_src_a;
    logic [1:0]         alu_src_b;
    logic [1:0]         alu_op;
    logic [1:0]         pc_source;
    logic               illegal_op;
    logic [COUNT_W-1:0] instr_count;

    modport master (
        input  opcode, mem_ready,
        output pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
               mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
               pc_source, illegal_op, instr_count
    );

    modport slave (
        output opcode, mem_ready,
        input  pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
               mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
               pc_source, illegal_op, instr_count
    );
endinterface : mc_ctrl_if
`default_nettype wire

// File: rtl/mc_ctrl_decode.sv
`default_nettype none
// ============================================================================
// Module      : mc_ctrl_decode
// Description : Combinational state (+ memory ready) to control word decode.
// Revision    : 1.0
// ============================================================================
module mc_ctrl_decode
    import mc_ctrl_pkg::*;
(
    input  state_t i_state,
    input  logic   i_mem_ready,
    output ctrl_t  o_ctrl
);

    always_comb begin
        o_ctrl = '0;
        case (i_state)
            ST_FETCH: begin
                o_ctrl.mem_read  = 1'b1;
                o_ctrl.alu_src_b = ALUB_FOUR;
                // IR and PC only commit once the instruction word is actually returned
                o_ctrl.ir_write  = i_mem_ready;
                o_ctrl.pc_write  = i_mem_ready;
            end
            ST_DECODE: begin
                o_ctrl.alu_src_b = ALUB_IMM_SH2;
            end
            ST_MEM_ADDR: begin
                o_ctrl.alu_src_a = 1'b1;
                o_ctrl.alu_src_b = ALUB_IMM;
            end
            ST_MEM_RD: begin
                o_ctrl.mem_read = 1'b1;
                o_ctrl.i_or_d   = 1'b1;
            end
            ST_MEM_WB: begin
                o_ctrl.reg_write  = 1'b1;
                o_ctrl.mem_to_reg = 1'b1;
            end
            ST_MEM_WR: begin
                o_ctrl.i_or_d    = 1'b1;
                o_ctrl.mem_write = i_mem_ready;
            end
            ST_R_EXEC: begin
                o_ctrl.alu_src_a = 1'b1;
                o_ctrl.alu_op    = ALUOP_FUNCT;
            end
            ST_R_WB: begin
                o_ctrl.reg_write = 1'b1;
                o_ctrl.reg_dst   = 1'b1;
            end
            ST_I_EXEC: begin
                o_ctrl.alu_src_a = 1'b1;
                o_ctrl.alu_src_b = ALUB_IMM;
            end
            ST_I_WB: begin
                o_ctrl.reg_write = 1'b1;
            end
            ST_BRANCH: begin
                o_ctrl.alu_src_a     = 1'b1;
                o_ctrl.alu_op        = ALUOP_SUB;
                o_ctrl.pc_write_cond = 1'b1;
                o_ctrl.pc_source     = PCSRC_ALUOUT;
            end
            ST_JUMP: begin
                o_ctrl.pc_write  = 1'b1;
                o_ctrl.pc_source = PCSRC_JUMP;
            end
            default: o_ctrl = '0;
        endcase
    end

endmodule : mc_ctrl_decode
`default_nettype wire

// File: rtl/mc_control_unit.sv
`default_nettype none
// ============================================================================
// Module      : mc_control_unit
// Description : Multicycle processor control FSM with wait-state stalls,
//               retired-instruction counter and sticky illegal-opcode flag.
// Revision    : 1.0
// ============================================================================
module mc_control_unit
    import mc_ctrl_pkg::*;
#(
    parameter int COUNT_W     = 32,
    parameter bit MEM_WAIT_EN = 1'b1
)(
    input  wire logic  clk,
    input  wire logic  rst,
    mc_ctrl_if.master  bus
);

    state_t             r_state;
    state_t             w_next;
    logic [COUNT_W-1:0] r_count;
    logic               r_illegal;
    logic               w_ready;
    ctrl_t              w_ctrl;

    generate
        if (MEM_WAIT_EN) begin : g_mem_wait
            assign w_ready = bus.mem_ready;
        end else begin : g_no_wait
            assign w_ready = 1'b1;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_FETCH;
            r_count   <= '0;
            r_illegal <= 1'b0;
        end else begin
            r_state <= w_next;
            // an instruction retires when control returns to FETCH from elsewhere
            if (r_state != ST_FETCH && w_next == ST_FETCH)
                r_count <= r_count + 1'b1;
            if (w_next == ST_TRAP)
                r_illegal <= 1'b1;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_FETCH:    w_next = w_ready ? ST_DECODE : ST_FETCH;
            ST_DECODE: begin
                case (bus.opcode)
                    OP_LW, OP_SW: w_next = ST_MEM_ADDR;
                    OP_RTYPE:     w_next = ST_R_EXEC;
                    OP_BEQ:       w_next = ST_BRANCH;
                    OP_J:         w_next = ST_JUMP;
                    OP_ADDI:      w_next = ST_I_EXEC;
                    default:      w_next = ST_TRAP;
                endcase
            end
            ST_MEM_ADDR: w_next = (bus.opcode == OP_LW) ? ST_MEM_RD : ST_MEM_WR;
            ST_MEM_RD:   w_next = w_ready ? ST_MEM_WB : ST_MEM_RD;
            ST_MEM_WB:   w_next = ST_FETCH;
            ST_MEM_WR:   w_next = w_ready ? ST_FETCH : ST_MEM_WR;
            ST_R_EXEC:   w_next = ST_R_WB;
            ST_R_WB:     w_next = ST_FETCH;
            ST_I_EXEC:   w_next = ST_I_WB;
            ST_I_WB:     w_next = ST_FETCH;
            ST_BRANCH:   w_next = ST_FETCH;
            ST_JUMP:     w_next = ST_FETCH;
            ST_TRAP:     w_next = ST_TRAP;
            default:     w_next = ST_FETCH;
        endcase
    end

    mc_ctrl_decode u_decode (
        .i_state     (r_state),
        .i_mem_ready (w_ready),
        .o_ctrl      (w_ctrl)
    );

    // Enables are suppressed during reset so no write escapes from a stale state
    assign bus.pc_write      = w_ctrl.pc_write      & ~rst;
    assign bus.pc_write_cond = w_ctrl.pc_write_cond & ~rst;
    assign bus.ir_write      = w_ctrl.ir_write      & ~rst;
    assign bus.mem_read      = w_ctrl.mem_read      & ~rst;
    assign bus.mem_write     = w_ctrl.mem_write     & ~rst;
    assign bus.reg_write     = w_ctrl.reg_write     & ~rst;
    assign bus.i_or_d        = w_ctrl.i_or_d;
    assign bus.mem_to_reg    = w_ctrl.mem_to_reg;
    assign bus.reg_dst       = w_ctrl.reg_dst;
    assign bus.alu_src_a     = w_ctrl.alu_src_a;
    assign bus.alu_src_b     = w_ctrl.alu_src_b;
    assign bus.alu_op        = w_ctrl.alu_op;
    assign bus.pc_source     = w_ctrl.pc_source;
    assign bus.illegal_op    = r_illegal;
    assign bus.instr_count   = r_count;

endmodule : mc_control_unit
`default_nettype wire

// File: tb/tb_mc_control_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_mc_control_unit
// Description : Self-checking bench for mc_control_unit against a per-instruction
//               phase model; second instance covers MEM_WAIT_EN=0 and counter wrap.
// Revision    : 1.0
// ============================================================================
module tb_mc_control_unit;

    typedef enum int {
        P_FETCH, P_DEC, P_ADDR, P_LOAD, P_LWB, P_STORE,
        P_REX, P_RWB, P_IEX, P_IWB, P_BR, P_JMP
    } phase_e;
    typedef phase_e phase_q_t[$];

    logic clk = 1'b0;
    logic rst;
    logic rst2;
    int   total   = 0;
    int   bad     = 0;
    int   exp_cnt = 0;
    int   exp_cnt2 = 0;

    always #5 clk = ~clk;

    mc_ctrl_if #(.COUNT_W(32)) bus  ();
    mc_ctrl_if #(.COUNT_W(4))  bus2 ();

    mc_control_unit #(.COUNT_W(32), .MEM_WAIT_EN(1'b1)) dut (
        .clk (clk), .rst (rst),  .bus (bus.master)
    );
    mc_control_unit #(.COUNT_W(4),  .MEM_WAIT_EN(1'b0)) dut_nw (
        .clk (clk), .rst (rst2), .bus (bus2.master)
    );

    // Instruction = ordered list of phases taken from the opcode rules
    function automatic phase_q_t seq_of(input logic [5:0] op);
        phase_q_t q;
        q.push_back(P_FETCH);
        q.push_back(P_DEC);
        case (op)
            6'h23: begin q.push_back(P_ADDR); q.push_back(P_LOAD); q.push_back(P_LWB); end
            6'h2B: begin q.push_back(P_ADDR); q.push_back(P_STORE); end
            6'h00: begin q.push_back(P_REX);  q.push_back(P_RWB); end
            6'h08: begin q.push_back(P_IEX);  q.push_back(P_IWB); end
            6'h04: q.push_back(P_BR);
            6'h02: q.push_back(P_JMP);
            default: ;
        endcase
        return q;
    endfunction

    // Packed as {pcw,pcc,iod,mr,mw,irw,m2r,rdst,rw,srca,srcb[2],aluop[2],pcsrc[2]}
    function automatic logic [15:0] exp_ctrl(input phase_e p, input bit r);
        logic pcw = 0, pcc = 0, iod = 0, mr = 0, mw = 0, irw = 0;
        logic m2r = 0, rd = 0, rw = 0, sa = 0;
        logic [1:0] sb = 2'd0, op = 2'd0, ps = 2'd0;
        case (p)
            P_FETCH: begin mr = 1; sb = 2'b01; irw = r; pcw = r; end
            P_DEC:   sb = 2'b11;
            P_ADDR:  begin sa = 1; sb = 2'b10; end
            P_LOAD:  begin mr = 1; iod = 1; end
            P_LWB:   begin rw = 1; m2r = 1; end
            P_STORE: begin iod = 1; mw = r; end
            P_REX:   begin sa = 1; op = 2'b10; end
            P_RWB:   begin rw = 1; rd = 1; end
            P_IEX:   begin sa = 1; sb = 2'b10; end
            P_IWB:   rw = 1;
            P_BR:    begin sa = 1; op = 2'b01; pcc = 1; ps = 2'b01; end
            P_JMP:   begin pcw = 1; ps = 2'b10; end
            default: ;
        endcase
        return {pcw, pcc, iod, mr, mw, irw, m2r, rd, rw, sa, sb, op, ps};
    endfunction

    function automatic logic [15:0] act_ctrl(input bit nw);
        if (nw)
            return {bus2.pc_write, bus2.pc_write_cond, bus2.i_or_d, bus2.mem_read,
                    bus2.mem_write, bus2.ir_write, bus2.mem_to_reg, bus2.reg_dst,
                    bus2.reg_write, bus2.alu_src_a, bus2.alu_src_b, bus2.alu_op,
                    bus2.pc_source};
        return {bus.pc_write, bus.pc_write_cond, bus.i_or_d, bus.mem_read,
                bus.mem_write, bus.ir_write, bus.mem_to_reg, bus.reg_dst,
                bus.reg_write, bus.alu_src_a, bus.alu_src_b, bus.alu_op,
                bus.pc_source};
    endfunction

    // One full instruction; mem_ready from mask (bit per cycle) or random
    task automatic run_instr(input bit nw, input logic [5:0] op, input logic [31:0] mask,
                             input bit use_mask, input string tag);
        phase_q_t    q;
        int          idx = 0;
        int          cyc = 0;
        bit          rdy;
        bit          eff;
        logic [15:0] e;
        logic [15:0] a;
        q = seq_of(op);
        while (idx < q.size()) begin
            @(negedge clk);
            if (use_mask) rdy = (cyc < 32) ? mask[cyc] : 1'b1;
            else          rdy = (cyc < 20) ? ($urandom_range(0, 99) >= 30) : 1'b1;
            if (nw) begin bus2.opcode = op; bus2.mem_ready = rdy; end
            else    begin bus.opcode  = op; bus.mem_ready  = rdy; end
            #1;
            if (cyc == 0) begin
                total++;
                if (nw ? (bus2.instr_count !== 4'(exp_cnt2 % 16))
                       : (bus.instr_count  !== 32'(exp_cnt))) begin
                    bad++;
                    $display("FAIL %s count got=%0d want=%0d", tag,
                             nw ? int'(bus2.instr_count) : int'(bus.instr_count),
                             nw ? exp_cnt2 % 16 : exp_cnt);
                end
                total++;
                if ((nw ? bus2.illegal_op : bus.illegal_op) !== 1'b0) begin
                    bad++;
                    $display("FAIL %s illegal_op got=1 want=0", tag);
                end
            end
            eff = nw ? 1'b1 : rdy;
            e = exp_ctrl(q[idx], eff);
            a = act_ctrl(nw);
            total++;
            if (a !== e) begin
                bad++;
                $display("FAIL %s ctrl cyc=%0d phase=%s got=%h want=%h",
                         tag, cyc, q[idx].name(), a, e);
            end
            if (eff || !(q[idx] inside {P_FETCH, P_LOAD, P_STORE})) idx++;
            cyc++;
            if (cyc > 80) begin
                total++; bad++;
                $display("FAIL %s timeout got=%0d want<=80 cycles", tag, cyc);
                break;
            end
        end
        if (nw) exp_cnt2++; else exp_cnt++;
    endtask

    task automatic test_reset();
        rst = 1'b1; rst2 = 1'b1;
        bus.mem_ready = 1'b1;  bus.opcode = 6'h00;
        bus2.mem_ready = 1'b1; bus2.opcode = 6'h00;
        repeat (2) @(negedge clk);
        #1;
        total++;
        if ({bus.pc_write, bus.pc_write_cond, bus.ir_write, bus.mem_read,
             bus.mem_write, bus.reg_write} !== 6'b0) begin
            bad++;
            $display("FAIL reset_enables got=%b want=000000",
                     {bus.pc_write, bus.pc_write_cond, bus.ir_write, bus.mem_read,
                      bus.mem_write, bus.reg_write});
        end
        total++;
        if (bus.instr_count !== 32'd0 || bus.illegal_op !== 1'b0) begin
            bad++;
            $display("FAIL reset_status got cnt=%0d ill=%b want cnt=0 ill=0",
                     bus.instr_count, bus.illegal_op);
        end
        @(negedge clk);
        rst = 1'b0; bus.mem_ready = 1'b0;
        #1;
        total++;
        if (act_ctrl(0) !== exp_ctrl(P_FETCH, 1'b0)) begin
            bad++;
            $display("FAIL reset_first_fetch got=%h want=%h", act_ctrl(0), exp_ctrl(P_FETCH, 1'b0));
        end
    endtask

    task automatic test_rtype();
        run_instr(0, 6'h00, 32'hFFFF_FFFF, 1, "rtype");
        run_instr(0, 6'h08, 32'hFFFF_FFFF, 1, "addi");
    endtask

    task automatic test_lw_wait();
        run_instr(0, 6'h23, 32'hFFFF_FFE7, 1, "lw_wait");
        run_instr(0, 6'h23, 32'hFFFF_FFFE, 1, "lw_fetch_wait");
    endtask

    task automatic test_store_branch();
        run_instr(0, 6'h2B, 32'hFFFF_FFF7, 1, "sw_wait");
        run_instr(0, 6'h2B, 32'hFFFF_FFFF, 1, "sw");
        run_instr(0, 6'h04, 32'hFFFF_FFFF, 1, "beq");
        run_instr(0, 6'h02, 32'hFFFF_FFFE, 1, "j");
    endtask

    task automatic test_random();
        logic [5:0] legal [6] = '{6'h00, 6'h23, 6'h2B, 6'h04, 6'h02, 6'h08};
        for (int i = 0; i < 30; i++)
            run_instr(0, legal[$urandom_range(0, 5)], 32'h0, 0, "random");
    endtask

    task automatic test_trap();
        @(negedge clk);
        bus.opcode = 6'h3F; bus.mem_ready = 1'b1;
        @(negedge clk); #1;
        total++;
        if (act_ctrl(0) !== exp_ctrl(P_DEC, 1'b1) || bus.illegal_op !== 1'b0) begin
            bad++;
            $display("FAIL trap_decode got=%h ill=%b want=%h ill=0",
                     act_ctrl(0), bus.illegal_op, exp_ctrl(P_DEC, 1'b1));
        end
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            bus.mem_ready = 1'($urandom_range(0, 1));
            #1;
            total++;
            if (act_ctrl(0) !== 16'h0 || bus.illegal_op !== 1'b1 ||
                bus.instr_count !== 32'(exp_cnt)) begin
                bad++;
                $display("FAIL trap_hold cyc=%0d got ctrl=%h ill=%b cnt=%0d want ctrl=0 ill=1 cnt=%0d",
                         i, act_ctrl(0), bus.illegal_op, bus.instr_count, exp_cnt);
            end
        end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk); #1;
        exp_cnt = 0;
        total++;
        if (bus.illegal_op !== 1'b0 || bus.instr_count !== 32'd0) begin
            bad++;
            $display("FAIL trap_clear got ill=%b cnt=%0d want ill=0 cnt=0",
                     bus.illegal_op, bus.instr_count);
        end
        rst = 1'b0; bus.mem_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        phase_e ph [4] = '{P_FETCH, P_DEC, P_ADDR, P_LOAD};
        run_instr(0, 6'h00, 32'hFFFF_FFFF, 1, "pre_abort");
        bus.opcode = 6'h23;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            bus.mem_ready = (i < 3);
            #1;
            total++;
            if (act_ctrl(0) !== exp_ctrl(ph[i], i < 3)) begin
                bad++;
                $display("FAIL abort_lead cyc=%0d got=%h want=%h", i, act_ctrl(0), exp_ctrl(ph[i], i < 3));
            end
        end
        @(negedge clk);
        rst = 1'b1; bus.mem_ready = 1'b1;
        #1;
        total++;
        if ({bus.mem_read, bus.reg_write, bus.mem_write, bus.pc_write} !== 4'b0) begin
            bad++;
            $display("FAIL abort_forced got=%b want=0000",
                     {bus.mem_read, bus.reg_write, bus.mem_write, bus.pc_write});
        end
        @(negedge clk);
        rst = 1'b0; bus.mem_ready = 1'b0;
        exp_cnt = 0;
        #1;
        total++;
        if (act_ctrl(0) !== exp_ctrl(P_FETCH, 1'b0) || bus.instr_count !== 32'd0) begin
            bad++;
            $display("FAIL abort_fetch got=%h cnt=%0d want=%h cnt=0",
                     act_ctrl(0), bus.instr_count, exp_ctrl(P_FETCH, 1'b0));
        end
        run_instr(0, 6'h08, 32'hFFFF_FFFF, 1, "post_abort");
    endtask

    task automatic test_no_wait();
        logic [5:0] legal [6] = '{6'h00, 6'h23, 6'h2B, 6'h04, 6'h02, 6'h08};
        @(posedge clk); #1;
        rst2 = 1'b0;
        for (int i = 0; i < 20; i++)
            run_instr(1, legal[$urandom_range(0, 5)], 32'h0, 0, "nowait");
        @(negedge clk); #1;
        total++;
        if (bus2.instr_count !== 4'(exp_cnt2 % 16)) begin
            bad++;
            $display("FAIL nowait_wrap got=%0d want=%0d", bus2.instr_count, exp_cnt2 % 16);
        end
        rst2 = 1'b1;
    endtask

    initial begin
        test_reset();
        test_rtype();
        test_lw_wait();
        test_store_branch();
        test_random();
        test_trap();
        test_reset_mid();
        test_no_wait();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1);
    end

endmodule : tb_mc_control_unit
`default_nettype wire
